sisc_prog_sequencer: RTL and testbench

//  Parametrised instruction stimulus and self-check engine for the SISC core.

---
 rtl/sisc_prog_sequencer_pkg.sv | 21 ++
 rtl/sisc_prog_sequencer_seq_ram.sv | 24 ++
 rtl/sisc_prog_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_sisc_prog_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_prog_sequencer_pkg.sv
// Shared types and constants for the SISC program sequencer: FSM encoding,
// the halt opcode and the NOP instruction word.
package sisc_prog_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_CHK_REQ = 3'd3,
    ST_CHK_CMP = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_t;

  localparam logic [3:0]  OP_HALT  = 4'hF;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic is_halt(input logic [3:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/sisc_prog_sequencer_seq_ram.sv
// Single-write, single-read storage array with combinational read.
// Contents are deliberately not reset.
module sisc_prog_sequencer_seq_ram #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sisc_prog_sequencer.sv
// Issues a stored program to the SISC core at a fixed gap, then reads back
// selected registers through the debug port and checks them against a table.
module sisc_prog_sequencer
  import sisc_prog_sequencer_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int PROG_DEPTH = 16,
  parameter  int CHK_DEPTH  = 8,
  parameter  int ISSUE_GAP  = 5,
  parameter  int REG_AW     = 4,
  localparam int PA_W       = $clog2(PROG_DEPTH),
  localparam int CA_W       = $clog2(CHK_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              prog_we,
  input  logic [PA_W-1:0]   prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [PA_W:0]     prog_len,
  input  logic              exp_we,
  input  logic [CA_W-1:0]   exp_addr,
  input  logic [REG_AW-1:0] exp_reg,
  input  logic [DATA_W-1:0] exp_val,
  input  logic [CA_W:0]     chk_len,
  input  logic              start,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [REG_AW-1:0] rf_sel,
  input  logic [DATA_W-1:0] rf_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CA_W:0]     fail_cnt,
  output logic [CA_W-1:0]   fail_idx
);

  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [PA_W:0]  PROG_MAX = (PA_W+1)'(PROG_DEPTH);
  localparam logic [CA_W:0]  CHK_MAX  = (CA_W+1)'(CHK_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(ISSUE_GAP - 1);

  seq_state_t r_state, w_state_next;

  logic [PA_W-1:0]   r_pc;
  logic [CA_W-1:0]   r_ci;
  logic [PA_W:0]     r_plen;
  logic [CA_W:0]     r_clen;
  logic [GAP_W-1:0]  r_gap;
  logic [DATA_W-1:0] r_ir;
  logic              r_ir_valid;
  logic [CA_W:0]     r_fail_cnt;
  logic [CA_W-1:0]   r_fail_idx;

  logic                     w_idle_or_done;
  logic                     w_start_ok;
  logic [PA_W:0]            w_plen_in;
  logic [CA_W:0]            w_clen_in;
  logic                     w_gap_end;
  logic                     w_last_word;
  logic                     w_halt;
  logic                     w_last_chk;
  logic                     w_mismatch;
  logic [PA_W-1:0]          w_prog_raddr;
  logic [DATA_W-1:0]        w_prog_rdata;
  logic [REG_AW+DATA_W-1:0] w_exp_rdata;
  logic [REG_AW-1:0]        w_exp_reg;
  logic [DATA_W-1:0]        w_exp_val;

  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start_ok     = start && w_idle_or_done;
  assign w_plen_in      = (prog_len > PROG_MAX) ? PROG_MAX : prog_len;
  assign w_clen_in      = (chk_len > CHK_MAX) ? CHK_MAX : chk_len;
  assign w_gap_end      = (r_gap == GAP_LAST);
  assign w_last_word    = (({1'b0, r_pc} + (PA_W+1)'(1)) == r_plen);
  assign w_halt         = is_halt(r_ir[DATA_W-1 -: 4]);
  assign w_last_chk     = (({1'b0, r_ci} + (CA_W+1)'(1)) == r_clen);
  assign w_exp_reg      = w_exp_rdata[REG_AW+DATA_W-1 -: REG_AW];
  assign w_exp_val      = w_exp_rdata[DATA_W-1:0];
  assign w_mismatch     = (rf_data != w_exp_val);

  // The next word is fetched one cycle before it is presented so that a write
  // landing on the start edge cannot leak into the issued stream.
  assign w_prog_raddr = (r_state == ST_ISSUE) ? (r_pc + PA_W'(1)) : '0;

  sisc_prog_sequencer_seq_ram #(
    .WIDTH (DATA_W),
    .DEPTH (PROG_DEPTH)
  ) u_prog_ram (
    .clk     (clk),
    .i_we    (prog_we && w_idle_or_done),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_prog_raddr),
    .o_rdata (w_prog_rdata)
  );

  sisc_prog_sequencer_seq_ram #(
    .WIDTH (REG_AW + DATA_W),
    .DEPTH (CHK_DEPTH)
  ) u_exp_ram (
    .clk     (clk),
    .i_we    (exp_we && w_idle_or_done),
    .i_waddr (exp_addr),
    .i_wdata ({exp_reg, exp_val}),
    .i_raddr (r_ci),
    .o_rdata (w_exp_rdata)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_state_next = (w_plen_in == '0) ? ST_CHK_REQ : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_gap_end && (w_last_word || w_halt)) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_gap_end) w_state_next = (r_clen == '0) ? ST_DONE : ST_CHK_REQ;
      end
      ST_CHK_REQ: w_state_next = (r_clen == '0) ? ST_DONE : ST_CHK_CMP;
      ST_CHK_CMP: w_state_next = w_last_chk ? ST_DONE : ST_CHK_REQ;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_pc       <= '0;
      r_ci       <= '0;
      r_plen     <= '0;
      r_clen     <= '0;
      r_gap      <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_fail_cnt <= '0;
      r_fail_idx <= '0;
    end else begin
      r_ir_valid <= 1'b0;
      if (w_start_ok) begin
        r_plen     <= w_plen_in;
        r_clen     <= w_clen_in;
        r_pc       <= '0;
        r_ci       <= '0;
        r_gap      <= '0;
        r_fail_cnt <= '0;
        r_fail_idx <= '0;
        r_ir       <= (w_plen_in != '0) ? w_prog_rdata : DATA_W'(NOP_WORD);
        r_ir_valid <= (w_plen_in != '0);
      end else begin
        case (r_state)
          ST_ISSUE: begin
            if (w_gap_end) begin
              r_gap <= '0;
              if (w_last_word || w_halt) begin
                r_ir <= DATA_W'(NOP_WORD);
              end else begin
                r_pc       <= r_pc + PA_W'(1);
                r_ir       <= w_prog_rdata;
                r_ir_valid <= 1'b1;
              end
            end else begin
              r_gap <= r_gap + GAP_W'(1);
            end
          end
          ST_DRAIN: begin
            r_gap <= w_gap_end ? '0 : (r_gap + GAP_W'(1));
          end
          ST_CHK_CMP: begin
            if (w_mismatch) begin
              if (r_fail_cnt == '0) r_fail_idx <= r_ci;
              if (r_fail_cnt != CHK_MAX) r_fail_cnt <= r_fail_cnt + (CA_W+1)'(1);
            end
            // ci stops on the last entry rather than wrapping.
            if (!w_last_chk) r_ci <= r_ci + CA_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign ir       = r_ir;
  assign ir_valid = r_ir_valid;
  assign rf_sel   = ((r_state == ST_CHK_REQ) || (r_state == ST_CHK_CMP)) ? w_exp_reg : '0;
  assign busy     = !w_idle_or_done;
  assign done     = (r_state == ST_DONE);
  assign pass     = done && (r_fail_cnt == '0);
  assign fail_cnt = r_fail_cnt;
  assign fail_idx = r_fail_idx;

endmodule

// File: tb/tb_sisc_prog_sequencer.sv
// Bench for the program sequencer: a tiny behavioural core executes issued
// words, a scoreboard checks the issued stream, and run results are checked.
module tb_sisc_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [31:0] prog_data;
  logic [4:0]  prog_len;
  logic        exp_we;
  logic [2:0]  exp_addr;
  logic [3:0]  exp_reg;
  logic [31:0] exp_val;
  logic [3:0]  chk_len;
  logic        start;
  logic [31:0] ir;
  logic        ir_valid;
  logic [3:0]  rf_sel;
  logic [31:0] rf_data;
  logic        busy, done, pass;
  logic [3:0]  fail_cnt;
  logic [2:0]  fail_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] prog_model [16];
  logic [31:0] arith_prog [11];
  logic [31:0] halt_prog  [6];
  logic [31:0] regs       [16];
  logic        core_clr;
  logic [31:0] exp_ir_q   [$];

  always #5 clk = ~clk;

  sisc_prog_sequencer dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .exp_we    (exp_we),
    .exp_addr  (exp_addr),
    .exp_reg   (exp_reg),
    .exp_val   (exp_val),
    .chk_len   (chk_len),
    .start     (start),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .rf_sel    (rf_sel),
    .rf_data   (rf_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_cnt  (fail_cnt),
    .fail_idx  (fail_idx)
  );

  // Minimal core: op[31:28] rd[27:24] rs[23:20] rt[19:16] imm[15:0]; R0 reads as 0.
  always_ff @(posedge clk) begin
    if (core_clr) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (ir_valid && ir[27:24] != 4'd0) begin
      case (ir[31:28])
        4'h1: regs[ir[27:24]] <= regs[ir[23:20]] + {{16{ir[15]}}, ir[15:0]};
        4'h2: regs[ir[27:24]] <= regs[ir[23:20]] + regs[ir[19:16]];
        4'h3: regs[ir[27:24]] <= regs[ir[23:20]] << ir[4:0];
        4'h4: regs[ir[27:24]] <= regs[ir[23:20]] - regs[ir[19:16]];
        4'h5: regs[ir[27:24]] <= regs[ir[23:20]] & regs[ir[19:16]];
        default: ;
      endcase
    end
    rf_data <= regs[rf_sel];
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt,
                                      input logic [15:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_prog(input int addr, input logic [31:0] data);
    prog_we = 1'b1; prog_addr = 4'(addr); prog_data = data;
    tick();
    prog_we = 1'b0;
    prog_model[addr] = data;
  endtask

  task automatic write_exp(input int idx, input logic [3:0] r, input logic [31:0] v);
    exp_we = 1'b1; exp_addr = 3'(idx); exp_reg = r; exp_val = v;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic load_arith();
    for (int i = 0; i < 11; i++) write_prog(i, arith_prog[i]);
    write_exp(0, 4'd1, 32'h0000_0001);
    write_exp(1, 4'd2, 32'hFF00_0008);
    write_exp(2, 4'd3, 32'hFE00_0000);
    write_exp(3, 4'd4, 32'hFE00_0011);
    write_exp(4, 4'd5, 32'hFF00_0019);
  endtask

  // One run from start to done; coinc writes prog[0] on the start edge,
  // poke tries a restart plus a RAM write in mid-run.
  task automatic run_seq(input string name, input int plen, input int clen,
                         input bit coinc, input bit poke,
                         input int exp_cycles, input int exp_pulses,
                         input bit exp_pass, input int exp_fcnt, input int exp_fidx);
    int          cycles;
    int          pulses;
    logic [31:0] ir_or;
    core_clr = 1'b1;
    tick();
    core_clr = 1'b0;
    exp_ir_q.delete();
    for (int i = 0; i < plen && i < 16; i++) begin
      exp_ir_q.push_back(prog_model[i]);
      if (prog_model[i][31:28] == 4'hF) break;
    end
    prog_len = 5'(plen);
    chk_len  = 4'(clen);
    start    = 1'b1;
    if (coinc) begin
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = 32'h1000_0000;
    end
    tick();
    start = 1'b0;
    if (coinc) begin
      prog_we = 1'b0;
      prog_model[0] = 32'h1000_0000;
    end
    cycles = 1;
    pulses = 0;
    ir_or  = '0;
    while (!done && cycles < 400) begin
      start   = 1'b0;
      prog_we = 1'b0;
      if (ir_valid) begin
        pulses++;
        if (exp_ir_q.size() > 0) check_val({name, "_ir"}, ir, exp_ir_q.pop_front());
        else                     check_val({name, "_ir_unexpected"}, 32'(ir_valid), 32'd0);
      end
      ir_or |= ir;
      if (poke && cycles == 7) begin
        start = 1'b1;
        prog_we = 1'b1; prog_addr = 4'd2; prog_data = 32'hDEAD_BEEF;
      end
      if (poke && cycles == 8) check_val({name, "_busy_mid"}, 32'(busy), 32'd1);
      tick();
      cycles++;
    end
    start = 1'b0;
    prog_we = 1'b0;
    check_val({name, "_done"},    32'(done),     32'd1);
    check_val({name, "_cycles"},  32'(cycles),   32'(exp_cycles));
    check_val({name, "_pulses"},  32'(pulses),   32'(exp_pulses));
    check_val({name, "_ir_left"}, 32'(exp_ir_q.size()), 32'd0);
    check_val({name, "_busy"},    32'(busy),     32'd0);
    check_val({name, "_pass"},    32'(pass),     32'(exp_pass));
    check_val({name, "_failcnt"}, 32'(fail_cnt), 32'(exp_fcnt));
    check_val({name, "_failidx"}, 32'(fail_idx), 32'(exp_fidx));
    if (plen == 0) check_val({name, "_ir_nop"}, ir_or, 32'd0);
    $display("run %s: plen=%0d chk=%0d cycles=%0d pulses=%0d pass=%0d fail_cnt=%0d fail_idx=%0d",
             name, plen, clen, cycles, pulses, pass, fail_cnt, fail_idx);
  endtask

  initial begin
    arith_prog[0]  = 32'h0000_0000;
    arith_prog[1]  = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h0001);
    arith_prog[2]  = enc(4'h1, 4'd6, 4'd0, 4'd0, 16'h00FF);
    arith_prog[3]  = enc(4'h3, 4'd6, 4'd6, 4'd0, 16'd24);
    arith_prog[4]  = enc(4'h1, 4'd2, 4'd6, 4'd0, 16'h0008);
    arith_prog[5]  = enc(4'h2, 4'd3, 4'd6, 4'd6, 16'h0000);
    arith_prog[6]  = enc(4'h1, 4'd7, 4'd0, 4'd0, 16'h0011);
    arith_prog[7]  = enc(4'h2, 4'd4, 4'd3, 4'd7, 16'h0000);
    arith_prog[8]  = enc(4'h2, 4'd5, 4'd2, 4'd7, 16'h0000);
    arith_prog[9]  = enc(4'h4, 4'd9, 4'd5, 4'd1, 16'h0000);
    arith_prog[10] = enc(4'h5, 4'd8, 4'd5, 4'd1, 16'h0000);
    halt_prog[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h0001);
    halt_prog[1] = enc(4'h1, 4'd2, 4'd0, 4'd0, 16'h0002);
    halt_prog[2] = enc(4'h1, 4'd3, 4'd0, 4'd0, 16'h0003);
    halt_prog[3] = 32'hF000_0000;
    halt_prog[4] = enc(4'h1, 4'd4, 4'd0, 4'd0, 16'h0004);
    halt_prog[5] = enc(4'h1, 4'd5, 4'd0, 4'd0, 16'h0005);

    rst_f = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    exp_we = 1'b0; exp_addr = '0; exp_reg = '0; exp_val = '0; chk_len = '0;
    start = 1'b0; core_clr = 1'b1;
    repeat (3) tick();
    check_val("rst_ir",       ir,               32'd0);
    check_val("rst_ir_valid", 32'(ir_valid),    32'd0);
    check_val("rst_busy",     32'(busy),        32'd0);
    check_val("rst_done",     32'(done),        32'd0);
    check_val("rst_pass",     32'(pass),        32'd0);
    check_val("rst_failcnt",  32'(fail_cnt),    32'd0);
    check_val("rst_failidx",  32'(fail_idx),    32'd0);
    check_val("rst_rfsel",    32'(rf_sel),      32'd0);
    @(negedge clk);
    rst_f = 1'b1;
    core_clr = 1'b0;
    tick();

    load_arith();
    run_seq("arith", 11, 5, 1'b0, 1'b0, 71, 11, 1'b1, 0, 0);

    write_exp(4, 4'd5, 32'h0000_0000);
    run_seq("arith_bad_r5", 11, 5, 1'b1, 1'b0, 71, 11, 1'b0, 1, 4);
    write_exp(4, 4'd5, 32'hFF00_0019);

    run_seq("busy_poke", 11, 5, 1'b0, 1'b1, 71, 11, 1'b1, 0, 0);
    run_seq("readback", 11, 5, 1'b0, 1'b0, 71, 11, 1'b1, 0, 0);

    for (int i = 0; i < 6; i++) write_prog(i, halt_prog[i]);
    write_exp(0, 4'd3, 32'h0000_0003);
    write_exp(1, 4'd4, 32'h0000_0000);
    run_seq("halt", 6, 2, 1'b0, 1'b0, 30, 4, 1'b1, 0, 0);

    run_seq("empty", 0, 0, 1'b0, 1'b0, 2, 0, 1'b1, 0, 0);

    load_arith();
    prog_len = 5'd11; chk_len = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check_val("abort_busy_before", 32'(busy), 32'd1);
    rst_f = 1'b0;
    #1;
    check_val("abort_ir",   ir,         32'd0);
    check_val("abort_busy", 32'(busy),  32'd0);
    check_val("abort_done", 32'(done),  32'd0);
    $display("run abort: reset asserted mid-issue ir=%08h busy=%0d done=%0d", ir, busy, done);
    repeat (2) tick();
    @(negedge clk);
    rst_f = 1'b1;
    tick();
    run_seq("rerun", 11, 5, 1'b0, 1'b0, 71, 11, 1'b1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
